// File: rtl/regfile_write_bank.sv
// regfile_write_bank: write side of the integer register file.
//   - Decodes the write-back index into a one-hot enable (x0 never enabled).
//   - Holds NUM_REGS registers with byte-lane write masking; x0 reads as 0.
//   - Presents all registers in parallel on o_regs for the read-port muxes.
//   - A dump engine streams x[0..NUM_REGS-1] out, one per cycle, then
//     pulses o_dump_done.
// Ports:
//   i_clk, i_rst_n                       clock, async active-low reset
//   i_wr_en/i_wr_addr/i_wr_data/i_wr_bmask  write-back request
//   o_regs                               flat bus, slice i = x[i]
//   o_wr_onehot                          decoded write enable (comb)
//   i_dump_start                         dump request pulse
//   o_dump_busy/valid/idx/data/done      dump stream

// One architectural register with per-byte write enables.
module regfile_write_bank_word #(
  parameter int DATA_W = 32
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_we,
  input  logic [DATA_W/8-1:0]   i_bmask,
  input  logic [DATA_W-1:0]     i_data,
  output logic [DATA_W-1:0]     o_q
);
  localparam int NB = DATA_W / 8;

  logic [NB-1:0][7:0] r_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_q <= '0;
    end else if (i_we) begin
      for (int b = 0; b < NB; b++)
        if (i_bmask[b]) r_q[b] <= i_data[b*8 +: 8];
    end
  end

  assign o_q = r_q;
endmodule

module regfile_write_bank #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = 5
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_wr_en,
  input  logic [ADDR_W-1:0]          i_wr_addr,
  input  logic [DATA_W-1:0]          i_wr_data,
  input  logic [DATA_W/8-1:0]        i_wr_bmask,
  output logic [NUM_REGS*DATA_W-1:0] o_regs,
  output logic [NUM_REGS-1:0]        o_wr_onehot,
  input  logic                       i_dump_start,
  output logic                       o_dump_busy,
  output logic                       o_dump_valid,
  output logic [ADDR_W-1:0]          o_dump_idx,
  output logic [DATA_W-1:0]          o_dump_data,
  output logic                       o_dump_done
);
  typedef enum logic [1:0] {S_IDLE, S_DUMP, S_DONE} state_t;

  logic [NUM_REGS-1:0][DATA_W-1:0] w_regs;
  logic [NUM_REGS-1:0]             w_onehot;

  state_t            r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_idx,   w_idx_nxt;

  // x0 has no storage at all: its slice and enable are tied off.
  for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
    if (i == 0) begin : g_zero
      assign w_onehot[i] = 1'b0;
      assign w_regs[i]   = '0;
    end else begin : g_word
      assign w_onehot[i] = i_wr_en && (i_wr_addr == ADDR_W'(i));
      regfile_write_bank_word #(.DATA_W(DATA_W)) u_word (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_we    (w_onehot[i]),
        .i_bmask (i_wr_bmask),
        .i_data  (i_wr_data),
        .o_q     (w_regs[i])
      );
    end
  end

  assign o_regs      = w_regs;
  assign o_wr_onehot = w_onehot;

  // Dump FSM: state register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
    end
  end

  // Dump FSM: next state. Start is only honoured from IDLE; the walk ends
  // on the terminal index compare rather than on counter wrap.
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    case (r_state)
      S_IDLE: if (i_dump_start) begin
        w_state_nxt = S_DUMP;
        w_idx_nxt   = '0;
      end
      S_DUMP: if (r_idx == ADDR_W'(NUM_REGS-1)) begin
        w_state_nxt = S_DONE;
        w_idx_nxt   = '0;
      end else begin
        w_idx_nxt = r_idx + 1'b1;
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Dump FSM: outputs. Data is the registered value, so a same-cycle write
  // to the dumped index is not visible until the next cycle.
  always_comb begin
    o_dump_busy  = 1'b0;
    o_dump_valid = 1'b0;
    o_dump_idx   = '0;
    o_dump_data  = '0;
    o_dump_done  = 1'b0;
    case (r_state)
      S_DUMP: begin
        o_dump_busy  = 1'b1;
        o_dump_valid = 1'b1;
        o_dump_idx   = r_idx;
        o_dump_data  = w_regs[r_idx];
      end
      S_DONE:  o_dump_done = 1'b1;
      default: ;
    endcase
  end
endmodule
